fitness_eval_pipe: RTL and testbench

//  Parametrised lattice fitness evaluator. Replaces the fixed 11-site/3-type evaluator in the GA loop.
//  Per individual: E = sum_i SE[p_i] + sum_adjacent 2*IM[p_i][p_(i+1)].

---
 rtl/fitness_eval_pipe.sv | 163 ++++++++++++++++
 tb/tb_fitness_eval_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fitness_eval_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fitness_eval_pipe                                             |
// | Brief    : 3-stage lattice fitness evaluator with valid/ready flow,      |
// |            optional ring boundary and per-population best tracking.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fitness_eval_pipe #(
  parameter int NUM_PARTICLE_TYPE = 3,
  parameter int DATA_WIDTH        = 4,
  parameter int LATTICE_LENGTH    = 11,
  parameter int ENERGY_WIDTH      = 10,
  parameter int POP_SIZE          = 50,
  parameter int IDX_WIDTH         = 6
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_n,
  input  logic                                                  wr_initial_i,
  input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]               self_energy_vec_i,
  input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
  input  logic                                                  ring_mode_i,
  output logic                                                  cfg_ready_o,
  input  logic                                                  in_valid_i,
  output logic                                                  in_ready_o,
  input  logic [LATTICE_LENGTH*DATA_WIDTH-1:0]                  individual_vec_i,
  output logic                                                  out_valid_ff_o,
  input  logic                                                  out_ready_i,
  output logic [ENERGY_WIDTH-1:0]                               total_energy_ff_o,
  output logic                                                  bad_code_ff_o,
  output logic                                                  done_ff_o,
  output logic [ENERGY_WIDTH-1:0]                               best_energy_o,
  output logic [IDX_WIDTH-1:0]                                  best_idx_o
);

  localparam int c_SE_W = NUM_PARTICLE_TYPE * DATA_WIDTH;
  localparam int c_IM_W = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
  localparam int c_IND_W = LATTICE_LENGTH * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(POP_SIZE - 1);

  logic [c_SE_W-1:0]       r_se_tab, r_se_prev, w_se_sel;
  logic [c_IM_W-1:0]       r_im_tab, r_im_prev, w_im_sel;
  logic                    r_s1_valid, r_s1_ring, r_s1_old_tab;
  logic [c_IND_W-1:0]      r_s1_ind;
  logic                    r_s2_valid, r_s2_bad;
  logic [ENERGY_WIDTH-1:0] r_s2_se_sum, r_s2_pair_sum;
  logic                    r_out_valid, r_out_bad, r_done;
  logic [ENERGY_WIDTH-1:0] r_out_energy, r_best_energy;
  logic [IDX_WIDTH-1:0]    r_best_idx, r_pop_cnt;
  logic                    w_en, w_cfg_wr, w_out_hs, w_pop_last, w_bad;
  logic [ENERGY_WIDTH-1:0] w_se_sum, w_pair_sum;
  int                      w_code  [LATTICE_LENGTH];
  logic                    w_legal [LATTICE_LENGTH];

  assign w_en        = ~r_out_valid | out_ready_i;
  assign cfg_ready_o = ~r_s1_valid & ~r_s2_valid & ~r_out_valid & (r_pop_cnt == '0);
  assign w_cfg_wr    = wr_initial_i & cfg_ready_o;
  assign w_out_hs    = r_out_valid & out_ready_i;
  assign w_pop_last  = (r_pop_cnt == c_LAST_IDX);

  // An individual accepted on the same edge as a table write still sees the old tables.
  assign w_se_sel = r_s1_old_tab ? r_se_prev : r_se_tab;
  assign w_im_sel = r_s1_old_tab ? r_im_prev : r_im_tab;

  for (genvar gi = 0; gi < LATTICE_LENGTH; gi++) begin : g_site
    assign w_code[gi]  = int'(r_s1_ind[gi*DATA_WIDTH +: DATA_WIDTH]);
    assign w_legal[gi] = (w_code[gi] < NUM_PARTICLE_TYPE);
  end

  always_comb begin
    w_se_sum   = '0;
    w_pair_sum = '0;
    w_bad      = 1'b0;
    for (int i = 0; i < LATTICE_LENGTH; i++) begin
      if (w_legal[i])
        w_se_sum = w_se_sum + ENERGY_WIDTH'(w_se_sel[w_code[i]*DATA_WIDTH +: DATA_WIDTH]);
      else
        w_bad = 1'b1;
    end
    // Pair (L-1,0) is the wrap pair; IM is directional, indexed [left][right].
    for (int i = 0; i < LATTICE_LENGTH; i++) begin
      if ((i < LATTICE_LENGTH - 1 || r_s1_ring) && w_legal[i] && w_legal[(i+1) % LATTICE_LENGTH])
        w_pair_sum = w_pair_sum + ENERGY_WIDTH'(w_im_sel[(w_code[i]*NUM_PARTICLE_TYPE +
                     w_code[(i+1) % LATTICE_LENGTH])*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_se_tab  <= '0;
      r_im_tab  <= '0;
      r_se_prev <= '0;
      r_im_prev <= '0;
    end else if (w_cfg_wr) begin
      r_se_prev <= r_se_tab;
      r_im_prev <= r_im_tab;
      r_se_tab  <= self_energy_vec_i;
      r_im_tab  <= interact_matrix_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_ring     <= 1'b0;
      r_s1_old_tab  <= 1'b0;
      r_s1_ind      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_bad      <= 1'b0;
      r_s2_se_sum   <= '0;
      r_s2_pair_sum <= '0;
      r_out_valid   <= 1'b0;
      r_out_bad     <= 1'b0;
      r_out_energy  <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_ind     <= individual_vec_i;
        r_s1_ring    <= ring_mode_i;
        r_s1_old_tab <= w_cfg_wr;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_se_sum   <= w_se_sum;
        r_s2_pair_sum <= w_pair_sum;
        r_s2_bad      <= w_bad;
      end
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_energy <= r_s2_se_sum + {r_s2_pair_sum[ENERGY_WIDTH-2:0], 1'b0};
        r_out_bad    <= r_s2_bad;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_cnt     <= '0;
      r_done        <= 1'b0;
      r_best_energy <= '0;
      r_best_idx    <= '0;
    end else begin
      r_done <= w_out_hs & w_pop_last;
      if (w_out_hs) begin
        r_pop_cnt <= w_pop_last ? '0 : r_pop_cnt + 1'b1;
        // First result of a population always seeds best; strict < keeps the earlier index on ties.
        if (r_pop_cnt == '0 || r_out_energy < r_best_energy) begin
          r_best_energy <= r_out_energy;
          r_best_idx    <= r_pop_cnt;
        end
      end
    end
  end

  assign in_ready_o        = w_en;
  assign out_valid_ff_o    = r_out_valid;
  assign total_energy_ff_o = r_out_energy;
  assign bad_code_ff_o     = r_out_bad;
  assign done_ff_o         = r_done;
  assign best_energy_o     = r_best_energy;
  assign best_idx_o        = r_best_idx;

endmodule
`default_nettype wire

// File: tb/tb_fitness_eval_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fitness_eval_pipe                                          |
// | Brief    : Self-checking bench for fitness_eval_pipe (POP_SIZE=4).       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fitness_eval_pipe;

  localparam int NPT = 3, DW = 4, L = 11, EW = 10, POP = 4, IW = 6;
  localparam logic [NPT*DW-1:0]     T1_SE = 12'h321;
  localparam logic [NPT*NPT*DW-1:0] T1_IM = 36'h1;
  localparam logic [NPT*NPT*DW-1:0] T2_IM = 36'h3020;
  localparam logic [L*DW-1:0]       I_ZERO = 44'h0;
  localparam logic [L*DW-1:0]       I_ALT  = 44'h01010101010;
  localparam logic [L*DW-1:0]       I_BAD  = 44'h00000300000;

  logic                    clk_i = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    wr_initial_i = 1'b0;
  logic [NPT*DW-1:0]       self_energy_vec_i = '0;
  logic [NPT*NPT*DW-1:0]   interact_matrix_i = '0;
  logic                    ring_mode_i = 1'b0;
  logic                    in_valid_i = 1'b0;
  logic [L*DW-1:0]         individual_vec_i = '0;
  logic                    out_ready_i = 1'b1;
  logic                    cfg_ready_o, in_ready_o, out_valid_ff_o, bad_code_ff_o, done_ff_o;
  logic [EW-1:0]           total_energy_ff_o, best_energy_o;
  logic [IW-1:0]           best_idx_o;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference state
  logic [NPT*DW-1:0]     m_se = '0;
  logic [NPT*NPT*DW-1:0] m_im = '0;
  int                    m_pop = 0, m_best = 0, m_idx = 0;
  logic                  m_done = 1'b0;

  fitness_eval_pipe #(
    .NUM_PARTICLE_TYPE(NPT), .DATA_WIDTH(DW), .LATTICE_LENGTH(L),
    .ENERGY_WIDTH(EW), .POP_SIZE(POP), .IDX_WIDTH(IW)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .wr_initial_i(wr_initial_i),
    .self_energy_vec_i(self_energy_vec_i), .interact_matrix_i(interact_matrix_i),
    .ring_mode_i(ring_mode_i), .cfg_ready_o(cfg_ready_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .individual_vec_i(individual_vec_i),
    .out_valid_ff_o(out_valid_ff_o), .out_ready_i(out_ready_i),
    .total_energy_ff_o(total_energy_ff_o), .bad_code_ff_o(bad_code_ff_o),
    .done_ff_o(done_ff_o), .best_energy_o(best_energy_o), .best_idx_o(best_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Energy straight from the definition: site energies plus doubled neighbour interactions.
  function automatic logic [EW:0] model_energy(input logic [L*DW-1:0] ind, input logic ring,
      input logic [NPT*DW-1:0] se, input logic [NPT*NPT*DW-1:0] im);
    int code [L];
    int e, a, c, npairs;
    logic b;
    e = 0;
    b = 1'b0;
    for (int i = 0; i < L; i++) code[i] = int'(ind[i*DW +: DW]);
    for (int i = 0; i < L; i++) begin
      if (code[i] < NPT) e += int'(se[code[i]*DW +: DW]);
      else b = 1'b1;
    end
    npairs = ring ? L : L - 1;
    for (int p = 0; p < npairs; p++) begin
      a = code[p];
      c = code[(p + 1) % L];
      if (a < NPT && c < NPT) e += 2 * int'(im[(a*NPT + c)*DW +: DW]);
    end
    return {b, EW'(e)};
  endfunction

  task automatic model_hs(input int e);
    if (m_pop == 0 || e < m_best) begin
      m_best = e;
      m_idx  = m_pop;
    end
    m_done = (m_pop == POP - 1);
    m_pop  = (m_pop == POP - 1) ? 0 : m_pop + 1;
  endtask

  task automatic model_clear();
    m_se = '0; m_im = '0; m_pop = 0; m_best = 0; m_idx = 0; m_done = 1'b0;
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0; wr_initial_i = 1'b0; out_ready_i = 1'b1; ring_mode_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic load_tables(input logic [NPT*DW-1:0] se, input logic [NPT*NPT*DW-1:0] im);
    wr_initial_i = 1'b1; self_energy_vec_i = se; interact_matrix_i = im;
    @(posedge clk_i); #1;
    wr_initial_i = 1'b0;
    m_se = se; m_im = im;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    n_checks++; if (out_valid_ff_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_ff_o); end
    n_checks++; if (total_energy_ff_o !== '0) begin n_bad++; $display("FAIL reset_energy got=%0d want=0", total_energy_ff_o); end
    n_checks++; if ({bad_code_ff_o, done_ff_o} !== 2'b00) begin n_bad++; $display("FAIL reset_bad_done got=%b want=00", {bad_code_ff_o, done_ff_o}); end
    n_checks++; if (best_energy_o !== '0 || best_idx_o !== '0) begin n_bad++; $display("FAIL reset_best got=%0d/%0d want=0/0", best_energy_o, best_idx_o); end
    n_checks++; if ({in_ready_o, cfg_ready_o} !== 2'b11) begin n_bad++; $display("FAIL reset_ready got=%b want=11", {in_ready_o, cfg_ready_o}); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    logic [NPT*NPT*DW-1:0] ims  [4] = '{T1_IM, T1_IM, T2_IM, T1_IM};
    logic [L*DW-1:0]       inds [4] = '{I_ZERO, I_ZERO, I_ALT, I_BAD};
    logic                  rings[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int                    want [4] = '{31, 33, 66, 26};
    logic                  wbad [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      load_tables(T1_SE, ims[k]);
      individual_vec_i = inds[k]; ring_mode_i = rings[k]; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      lat = 0;
      for (int n = 1; n <= 6 && lat == 0; n++) begin
        @(negedge clk_i);
        if (out_valid_ff_o === 1'b1) lat = n;
      end
      n_checks++; if (lat != 3) begin n_bad++; $display("FAIL directed%0d_latency got=%0d want=3", k, lat); end
      n_checks++; if (total_energy_ff_o !== EW'(want[k])) begin n_bad++; $display("FAIL directed%0d_energy got=%0d want=%0d", k, total_energy_ff_o, want[k]); end
      n_checks++; if (bad_code_ff_o !== wbad[k]) begin n_bad++; $display("FAIL directed%0d_bad_code got=%b want=%b", k, bad_code_ff_o, wbad[k]); end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [L*DW-1:0] inds [8];
    logic            rings[8];
    logic [NPT*DW-1:0] se;
    logic [NPT*NPT*DW-1:0] im;
    logic [EW:0] exp_q[$];
    logic [EW:0] ex;
    logic done_exp;
    int sent, recv, cyc;
    do_reset();
    for (int k = 0; k < NPT; k++) se[k*DW +: DW] = 4'($urandom_range(0, 15));
    for (int k = 0; k < NPT*NPT; k++) im[k*DW +: DW] = 4'($urandom_range(0, 15));
    load_tables(se, im);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < L; i++)
        inds[n][i*DW +: DW] = ($urandom_range(0, 15) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
      rings[n] = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; cyc = 0; done_exp = 1'b0;
    in_valid_i = 1'b1; individual_vec_i = inds[0]; ring_mode_i = rings[0]; out_ready_i = 1'b1;
    while (recv < 8 && cyc < 100) begin
      @(negedge clk_i);
      n_checks++; if (done_ff_o !== done_exp) begin n_bad++; $display("FAIL b2b_done cyc=%0d got=%b want=%b", cyc, done_ff_o, done_exp); end
      done_exp = 1'b0;
      if (!out_ready_i) begin
        n_checks++;
        if (in_ready_o !== 1'b0 || out_valid_ff_o !== 1'b1 || total_energy_ff_o !== exp_q[0][EW-1:0]) begin
          n_bad++; $display("FAIL b2b_stall_hold cyc=%0d got rdy=%b vld=%b e=%0d want rdy=0 vld=1 e=%0d",
                            cyc, in_ready_o, out_valid_ff_o, total_energy_ff_o, exp_q[0][EW-1:0]);
        end
      end else begin
        n_checks++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready_o); end
      end
      if (out_valid_ff_o === 1'b1 && out_ready_i) begin
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if ({bad_code_ff_o, total_energy_ff_o} !== ex) begin
          n_bad++; $display("FAIL b2b_result%0d got=%b/%0d want=%b/%0d", recv, bad_code_ff_o, total_energy_ff_o, ex[EW], ex[EW-1:0]);
        end
        model_hs(int'(ex[EW-1:0]));
        done_exp = m_done;
        recv++;
      end
      if (in_valid_i && in_ready_o === 1'b1) begin
        exp_q.push_back(model_energy(inds[sent], rings[sent], m_se, m_im));
        sent++;
      end
      @(posedge clk_i); #1;
      cyc++;
      out_ready_i = !(cyc >= 5 && cyc < 9);
      if (sent < 8) begin
        individual_vec_i = inds[sent]; ring_mode_i = rings[sent]; in_valid_i = 1'b1;
      end else in_valid_i = 1'b0;
    end
    n_checks++; if (recv != 8) begin n_bad++; $display("FAIL b2b_count got=%0d want=8", recv); end
    @(negedge clk_i);
    n_checks++; if (done_ff_o !== done_exp) begin n_bad++; $display("FAIL b2b_final_done got=%b want=%b", done_ff_o, done_exp); end
    n_checks++; if (best_energy_o !== EW'(m_best) || best_idx_o !== IW'(m_idx)) begin
      n_bad++; $display("FAIL b2b_best got=%0d/%0d want=%0d/%0d", best_energy_o, best_idx_o, m_best, m_idx);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_population();
    logic [L*DW-1:0] inds[5] = '{44'h02222222222, 44'h00000001222, 44'h00000001222,
                                 44'h00000222222, 44'h00000222222};
    int want[5] = '{20, 7, 7, 12, 12};
    logic done_exp;
    int sent, recv, cyc;
    do_reset();
    load_tables(12'h210, '0);
    sent = 0; recv = 0; cyc = 0; done_exp = 1'b0;
    in_valid_i = 1'b1; individual_vec_i = inds[0]; ring_mode_i = 1'b0; out_ready_i = 1'b1;
    while (recv < 5 && cyc < 60) begin
      @(negedge clk_i);
      n_checks++; if (done_ff_o !== done_exp) begin n_bad++; $display("FAIL pop_done cyc=%0d got=%b want=%b", cyc, done_ff_o, done_exp); end
      n_checks++; if (best_energy_o !== EW'(m_best) || best_idx_o !== IW'(m_idx)) begin
        n_bad++; $display("FAIL pop_best cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, best_energy_o, best_idx_o, m_best, m_idx);
      end
      if (done_exp) begin
        n_checks++; if (best_energy_o !== 10'd7 || best_idx_o !== 6'd1) begin
          n_bad++; $display("FAIL pop_best_at_done got=%0d/%0d want=7/1", best_energy_o, best_idx_o);
        end
      end
      done_exp = 1'b0;
      if (out_valid_ff_o === 1'b1) begin
        n_checks++; if (total_energy_ff_o !== EW'(want[recv])) begin
          n_bad++; $display("FAIL pop_energy%0d got=%0d want=%0d", recv, total_energy_ff_o, want[recv]);
        end
        model_hs(want[recv]);
        done_exp = m_done;
        recv++;
      end
      if (in_valid_i && in_ready_o === 1'b1) sent++;
      @(posedge clk_i); #1;
      cyc++;
      if (sent < 5) individual_vec_i = inds[sent];
      else in_valid_i = 1'b0;
    end
    @(negedge clk_i);
    n_checks++; if (best_energy_o !== 10'd12 || best_idx_o !== 6'd0 || done_ff_o !== 1'b0) begin
      n_bad++; $display("FAIL pop_reload got=%0d/%0d done=%b want=12/0 done=0", best_energy_o, best_idx_o, done_ff_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_cfg_rules();
    int got, nres;
    int res[4];
    // Load attempt while an individual is in flight must be ignored.
    do_reset();
    load_tables(T1_SE, T1_IM);
    individual_vec_i = I_ZERO; ring_mode_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    wr_initial_i = 1'b1; self_energy_vec_i = '1; interact_matrix_i = '1;
    @(negedge clk_i);
    n_checks++; if (cfg_ready_o !== 1'b0) begin n_bad++; $display("FAIL cfg_busy got=%b want=0", cfg_ready_o); end
    @(posedge clk_i); #1;
    wr_initial_i = 1'b0;
    individual_vec_i = I_ZERO; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    nres = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (out_valid_ff_o === 1'b1 && nres < 4) begin res[nres] = int'(total_energy_ff_o); nres++; end
    end
    n_checks++; if (nres != 2 || res[0] != 31 || res[1] != 31) begin
      n_bad++; $display("FAIL cfg_ignored got n=%0d e0=%0d e1=%0d want n=2 e0=31 e1=31", nres, res[0], res[1]);
    end
    n_checks++; if (cfg_ready_o !== 1'b0) begin n_bad++; $display("FAIL cfg_pop_nonzero got=%b want=0", cfg_ready_o); end
    @(posedge clk_i); #1;

    // Table write and accept on the same edge: that individual uses the old (zero) tables.
    do_reset();
    wr_initial_i = 1'b1; self_energy_vec_i = T1_SE; interact_matrix_i = T1_IM;
    individual_vec_i = I_ZERO; ring_mode_i = 1'b0; in_valid_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL simul_cfg_ready got=%b want=1", cfg_ready_o); end
    @(posedge clk_i); #1;
    wr_initial_i = 1'b0;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    nres = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (out_valid_ff_o === 1'b1 && nres < 4) begin res[nres] = int'(total_energy_ff_o); nres++; end
    end
    n_checks++; if (nres != 2 || res[0] != 0 || res[1] != 31) begin
      n_bad++; $display("FAIL simul_write got n=%0d e0=%0d e1=%0d want n=2 e0=0 e1=31", nres, res[0], res[1]);
    end
    got = nres;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    int nres, e0;
    do_reset();
    load_tables(T1_SE, T1_IM);
    individual_vec_i = I_ZERO; ring_mode_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (best_energy_o !== 10'd31) begin n_bad++; $display("FAIL rmid_pre_best got=%0d want=31", best_energy_o); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid_ff_o !== 1'b0 || best_energy_o !== '0 || best_idx_o !== '0) begin
      n_bad++; $display("FAIL rmid_cleared got vld=%b best=%0d idx=%0d want 0/0/0", out_valid_ff_o, best_energy_o, best_idx_o);
    end
    n_checks++; if ({in_ready_o, cfg_ready_o} !== 2'b11) begin n_bad++; $display("FAIL rmid_ready got=%b want=11", {in_ready_o, cfg_ready_o}); end
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    model_clear();
    individual_vec_i = I_ZERO; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    nres = 0; e0 = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (out_valid_ff_o === 1'b1) begin if (nres == 0) e0 = int'(total_energy_ff_o); nres++; end
    end
    n_checks++; if (nres != 1 || e0 != 0) begin
      n_bad++; $display("FAIL rmid_after got n=%0d e=%0d want n=1 e=0", nres, e0);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_population();
    test_cfg_rules();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
